// File: rtl/txd_rr_arbiter.sv
// Round-robin arbiter sharing one byte transmitter among N_REQ sources.
// One byte per grant. A watchdog aborts a transfer whose transmitter never reports completion.
module txd_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic [N_REQ-1:0]    iREQ_Start,
    input  logic [N_REQ*DW-1:0] iREQ_DATA,
    output logic [N_REQ-1:0]    oREQ_Grant,
    output logic [N_REQ-1:0]    oREQ_Done,
    output logic [DW-1:0]       oTXD_DATA,
    output logic                oTXD_Start,
    input  logic                iTXD_Done,
    output logic                oTimeout,
    output logic                oBusy
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int PW = $clog2(N_REQ);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] P_INIT = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_RELEASE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [N_REQ-1:0]  served_q, served_d;
    logic [DW-1:0]     data_q, data_d;
    logic              start_q, start_d;
    logic              timeout_q, timeout_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic [N_REQ-1:0]  elig;
    logic              pick_vld;
    logic [PW-1:0]     pick_idx;
    logic [DW-1:0]     req_byte [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_byte
        assign req_byte[gi] = iREQ_DATA[gi*DW +: DW];
    end

    // A requester still holding Start after its Done must drop it before it is eligible again.
    assign elig = iREQ_Start & ~served_q;

    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!pick_vld && elig[PW'(idx)]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(idx);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            served_q  <= '0;
            data_q    <= '0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= P_INIT;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            served_q  <= served_d;
            data_q    <= data_d;
            start_q   <= start_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (pick_vld) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (iTXD_Done || timer_q == T_LAST) state_d = S_RELEASE;
            S_RELEASE:   if (!iTXD_Done) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        done_d    = '0;
        data_d    = data_q;
        start_d   = start_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = N_REQ'(1) << pick_idx;
                    data_d  = req_byte[pick_idx];
                    start_d = 1'b1;
                    ptr_d   = pick_idx;
                    timer_d = '0;
                end
            end
            S_WAIT_DONE: begin
                if (timer_q != T_LAST) timer_d = timer_q + 1'b1;
                // A completion arriving on the watchdog's last cycle wins over the abort.
                if (iTXD_Done || timer_q == T_LAST) begin
                    start_d   = 1'b0;
                    done_d    = grant_q;
                    timeout_d = !iTXD_Done;
                end
            end
            S_RELEASE: begin
                if (!iTXD_Done) grant_d = '0;
            end
            default: begin
                grant_d = '0;
                start_d = 1'b0;
            end
        endcase
        served_d = (served_q & iREQ_Start) | done_d;
    end

    assign oREQ_Grant = grant_q;
    assign oREQ_Done  = done_q;
    assign oTXD_DATA  = data_q;
    assign oTXD_Start = start_q;
    assign oTimeout   = timeout_q;
    assign oBusy      = (state_q != S_IDLE);

endmodule
